// File: rtl/led_scan_ctrl.sv
// Step sequencer for a 3-to-8 active-low LED decoder: chase up/down, bounce or static
// hold patterns, advancing one position every DIV clocks.
module led_scan_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [2:0] sel_in,
    output logic       busy,
    output logic [2:0] switch,
    output logic [2:0] enable,
    output logic       wrap
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UP     = 3'd1,
        DOWN   = 3'd2,
        BOUNCE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    state_t     state_r, state_s;
    logic [2:0] pos_r, pos_s;
    logic [7:0] presc_r, presc_s;
    logic       dir_down_r, dir_down_s;
    logic       wrap_r, wrap_s;
    logic       busy_r, busy_s;
    logic [2:0] enable_r, enable_s;
    logic       tick_s;
    logic [2:0] pos_inc_s, pos_dec_s;

    // State and output registers; reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pos_r      <= 3'd0;
            presc_r    <= 8'd0;
            dir_down_r <= 1'b0;
            wrap_r     <= 1'b0;
            busy_r     <= 1'b0;
            enable_r   <= 3'b000;
        end else begin
            state_r    <= state_s;
            pos_r      <= pos_s;
            presc_r    <= presc_s;
            dir_down_r <= dir_down_s;
            wrap_r     <= wrap_s;
            busy_r     <= busy_s;
            enable_r   <= enable_s;
        end
    end

    // Next-state, position stepping and registered-output values.
    always_comb begin
        state_s    = state_r;
        pos_s      = pos_r;
        presc_s    = presc_r;
        dir_down_s = dir_down_r;
        wrap_s     = 1'b0;
        busy_s     = busy_r;
        enable_s   = enable_r;
        tick_s     = (presc_r == DIV_M1);
        pos_inc_s  = pos_r + 3'd1;
        pos_dec_s  = pos_r - 3'd1;

        case (state_r)
            IDLE: begin
                presc_s = 8'd0;
                if (start && !stop) begin
                    pos_s      = sel_in;
                    busy_s     = 1'b1;
                    enable_s   = 3'b100;
                    dir_down_s = (sel_in == 3'd7);
                    case (mode)
                        2'b00:   state_s = UP;
                        2'b01:   state_s = DOWN;
                        2'b10:   state_s = BOUNCE;
                        default: state_s = HOLD;
                    endcase
                end else begin
                    busy_s   = 1'b0;
                    enable_s = 3'b000;
                end
            end
            default: begin
                if (stop) begin
                    // Switch keeps its last value; the decoder is disabled anyway.
                    state_s  = IDLE;
                    presc_s  = 8'd0;
                    busy_s   = 1'b0;
                    enable_s = 3'b000;
                end else begin
                    presc_s = tick_s ? 8'd0 : presc_r + 8'd1;
                    if (tick_s) begin
                        case (state_r)
                            UP: begin
                                pos_s  = pos_inc_s;
                                wrap_s = (pos_inc_s == 3'd0);
                            end
                            DOWN: begin
                                pos_s  = pos_dec_s;
                                wrap_s = (pos_dec_s == 3'd7);
                            end
                            BOUNCE: begin
                                // Direction flips on arrival at an end, so pos never wraps.
                                if (dir_down_r) begin
                                    pos_s      = pos_dec_s;
                                    wrap_s     = (pos_dec_s == 3'd0);
                                    dir_down_s = (pos_dec_s != 3'd0);
                                end else begin
                                    pos_s      = pos_inc_s;
                                    wrap_s     = (pos_inc_s == 3'd7);
                                    dir_down_s = (pos_inc_s == 3'd7);
                                end
                            end
                            default: begin
                                pos_s = pos_r;
                            end
                        endcase
                    end else begin
                        pos_s = pos_r;
                    end
                end
            end
        endcase
    end

    assign busy   = busy_r;
    assign switch = pos_r;
    assign enable = enable_r;
    assign wrap   = wrap_r;

endmodule
